// File: rtl/flash_adc_pkg.sv
// Shared types and widths for the flash ADC sequencer.
package flash_adc_pkg;

  localparam int THERM_W = 7;
  localparam int BIN_W   = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LATCH   = 3'd1,
    SETTLE  = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Sum of 2^log2_nsamp counts of at most 7 always fits in BIN_W+log2_nsamp bits.
  function automatic int sum_w(input int log2_nsamp);
    return BIN_W + log2_nsamp;
  endfunction

endpackage

// File: rtl/therm_popcount_chk.sv
// Combinational 7-to-3 ones counter (full-adder tree) with a thermometer bubble check.
module therm_popcount_chk
  import flash_adc_pkg::*;
(
  input  logic [THERM_W-1:0] therm,
  output logic [BIN_W-1:0]   count,
  output logic               bubble
);

  logic s0, c0, s1, c1, s2, c2, s3, c3;

  assign s0 = therm[0] ^ therm[1] ^ therm[2];
  assign c0 = (therm[0] & therm[1]) | (therm[0] & therm[2]) | (therm[1] & therm[2]);
  assign s1 = therm[3] ^ therm[4] ^ therm[5];
  assign c1 = (therm[3] & therm[4]) | (therm[3] & therm[5]) | (therm[4] & therm[5]);
  assign s2 = s0 ^ s1 ^ therm[6];
  assign c2 = (s0 & s1) | (s0 & therm[6]) | (s1 & therm[6]);
  assign s3 = c0 ^ c1 ^ c2;
  assign c3 = (c0 & c1) | (c0 & c2) | (c1 & c2);

  assign count = {c3, s3, s2};

  // A set bit directly above a clear bit means some lower threshold did not trip.
  assign bubble = |(therm[THERM_W-1:1] & ~therm[THERM_W-2:0]);

endmodule

// File: rtl/flash_adc_sequencer.sv
// Flash comparator burst sequencer: latch, settle, capture, accumulate, rounded average.
// Define FLASH_ADC_RETRY_EN to re-sample a slot once after a bubbled capture.
//
// Handshakes: start is taken on a rising edge where start && start_ready; the
// result is consumed on a rising edge where result_valid && result_ready, and
// result/result_sum/bubble_err stay stable while result_valid is high.
module flash_adc_sequencer
  import flash_adc_pkg::*;
#(
  parameter int LOG2_NSAMP = 2,
  parameter int SETTLE_CYC = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           start_ready,
  output logic                           cmp_latch,
  input  logic [THERM_W-1:0]             therm_in,
  output logic                           busy,
  output logic [BIN_W-1:0]               result,
  output logic [sum_w(LOG2_NSAMP)-1:0]   result_sum,
  output logic                           result_valid,
  input  logic                           result_ready,
  output logic                           bubble_err,
  output state_t                         dbg_state
);

  localparam int SUM_W = sum_w(LOG2_NSAMP);
  localparam int NSAMP = 1 << LOG2_NSAMP;
  localparam int CNT_W = LOG2_NSAMP + 1;
  localparam int RND_I = (LOG2_NSAMP == 0) ? 0 : (1 << (LOG2_NSAMP - 1));
  localparam logic [SUM_W-1:0] RND = SUM_W'(RND_I);

  state_t             state, state_nxt;
  logic [SUM_W-1:0]   acc;
  logic [SUM_W-1:0]   acc_rnd;
  logic [CNT_W-1:0]   samp_cnt;
  logic [3:0]         settle_cnt;
  logic               bub_flag;
  logic [BIN_W-1:0]   cap_count;
  logic               cap_bubble;
  logic               take_sample;
  logic               last_samp;

  therm_popcount_chk u_popcount (
    .therm  (therm_in),
    .count  (cap_count),
    .bubble (cap_bubble)
  );

`ifdef FLASH_ADC_RETRY_EN
  logic retry;
  // First bubble in a slot is discarded and re-sampled; the second is kept.
  assign take_sample = !cap_bubble || retry;
`else
  assign take_sample = 1'b1;
`endif

  assign last_samp = (samp_cnt == CNT_W'(NSAMP - 1));
  assign acc_rnd   = acc + RND;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = LATCH;
      LATCH:   state_nxt = SETTLE;
      SETTLE:  if (settle_cnt <= 4'd1) state_nxt = CAPTURE;
      CAPTURE: state_nxt = (take_sample && last_samp) ? DONE : LATCH;
      DONE:    if (result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_ready  = 1'b0;
    busy         = 1'b1;
    cmp_latch    = 1'b0;
    result_valid = 1'b0;
    result       = '0;
    result_sum   = '0;
    bubble_err   = 1'b0;
    unique case (state)
      IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
      end
      LATCH: cmp_latch = 1'b1;
      DONE: begin
        result_valid = 1'b1;
        result_sum   = acc;
        result       = BIN_W'(acc_rnd >> LOG2_NSAMP);
        bubble_err   = bub_flag;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      samp_cnt   <= '0;
      settle_cnt <= '0;
      bub_flag   <= 1'b0;
`ifdef FLASH_ADC_RETRY_EN
      retry      <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: if (start) begin
          acc      <= '0;
          samp_cnt <= '0;
          bub_flag <= 1'b0;
`ifdef FLASH_ADC_RETRY_EN
          retry    <= 1'b0;
`endif
        end
        LATCH:  settle_cnt <= 4'(SETTLE_CYC);
        SETTLE: settle_cnt <= settle_cnt - 4'd1;
        CAPTURE: begin
          if (take_sample) begin
            acc      <= acc + SUM_W'(cap_count);
            bub_flag <= bub_flag | cap_bubble;
            samp_cnt <= samp_cnt + CNT_W'(1);
`ifdef FLASH_ADC_RETRY_EN
            retry    <= 1'b0;
          end else begin
            retry    <= 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_adc_sequencer.sv
// Directed bench for flash_adc_sequencer: default configuration plus a LOG2_NSAMP=0/SETTLE_CYC=1 instance.
module tb_flash_adc_sequencer;
  import flash_adc_pkg::*;

  localparam int SETTLE = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default instance
  logic       start = 1'b0, result_ready = 1'b0;
  logic [6:0] therm_in = '0;
  logic       start_ready, cmp_latch, busy, result_valid, bubble_err;
  logic [2:0] result;
  logic [4:0] result_sum;
  state_t     dbg_state;

  // single-sample instance
  logic       start_b = 1'b0, result_ready_b = 1'b0;
  logic [6:0] therm_in_b = '0;
  logic       start_ready_b, cmp_latch_b, busy_b, result_valid_b, bubble_err_b;
  logic [2:0] result_b;
  logic [2:0] result_sum_b;
  state_t     dbg_state_b;

  flash_adc_sequencer #(.LOG2_NSAMP(2), .SETTLE_CYC(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start), .start_ready(start_ready),
    .cmp_latch(cmp_latch), .therm_in(therm_in), .busy(busy),
    .result(result), .result_sum(result_sum), .result_valid(result_valid),
    .result_ready(result_ready), .bubble_err(bubble_err), .dbg_state(dbg_state)
  );

  flash_adc_sequencer #(.LOG2_NSAMP(0), .SETTLE_CYC(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .start_ready(start_ready_b),
    .cmp_latch(cmp_latch_b), .therm_in(therm_in_b), .busy(busy_b),
    .result(result_b), .result_sum(result_sum_b), .result_valid(result_valid_b),
    .result_ready(result_ready_b), .bubble_err(bubble_err_b), .dbg_state(dbg_state_b)
  );

  // scoreboard state
  int tests = 0;
  int failed = 0;
  logic [6:0] exp_q[$];   // codes presented at successive latch pulses
  int n_latch, done_lat, spacing_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Request a conversion and feed exp_q codes on each latch; returns at the
  // first negedge showing result_valid, or when the budget runs out.
  task automatic run_conv(input int budget);
    int last_latch;
    n_latch = 0; done_lat = -1; spacing_bad = 0; last_latch = -1;
    @(negedge clk);
    start = 1'b1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (cmp_latch) begin
        if (last_latch >= 0 && (i - last_latch) != 2 + SETTLE) spacing_bad++;
        last_latch = i;
        n_latch++;
        if (exp_q.size() > 0) therm_in = exp_q.pop_front();
      end
      if (result_valid) begin
        done_lat = i - 1;
        break;
      end
    end
  endtask

  task automatic accept_result(input string tag);
    result_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    chk({tag, "_idle_valid"}, result_valid, 1'b0);
    result_ready = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_start_ready", start_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmp_latch", cmp_latch, 1'b0);
    chk("rst_valid", result_valid, 1'b0);
    chk("rst_result", result, 3'd0);
    chk("rst_sum", result_sum, 5'd0);
    chk("rst_bubble", bubble_err, 1'b0);
    chk("rst_state", dbg_state, IDLE);
    chk("rst_b_ready", start_ready_b, 1'b1);
    chk("rst_b_state", dbg_state_b, IDLE);
    rst = 1'b0;

    // full-scale codes: timing, latch count and spacing
    repeat (4) exp_q.push_back(7'b1111111);
    run_conv(40);
    chk("full_latency", done_lat, 16);
    chk("full_latches", n_latch, 4);
    chk("full_spacing", spacing_bad, 0);
    chk("full_sum", result_sum, 5'd28);
    chk("full_result", result, 3'd7);
    chk("full_bubble", bubble_err, 1'b0);

    // hold in DONE with a stray start request
    for (int k = 0; k < 5; k++) begin
      start = (k == 2);
      @(negedge clk);
      chk("hold_valid", result_valid, 1'b1);
      chk("hold_result", result, 3'd7);
      chk("hold_sum", result_sum, 5'd28);
      chk("hold_start_ready", start_ready, 1'b0);
    end
    // start coinciding with the accept must be ignored
    start = 1'b1;
    result_ready = 1'b1;
    @(negedge clk);
    chk("accept_busy", busy, 1'b0);
    chk("accept_start_ready", start_ready, 1'b1);
    chk("accept_valid", result_valid, 1'b0);
    start = 1'b0;
    result_ready = 1'b0;

    // mixed codes, rounding (14+2)>>2
    exp_q.push_back(7'b0000111);
    exp_q.push_back(7'b0001111);
    exp_q.push_back(7'b0000111);
    exp_q.push_back(7'b0001111);
    run_conv(40);
    chk("mix_sum", result_sum, 5'd14);
    chk("mix_result", result, 3'd4);
    chk("mix_bubble", bubble_err, 1'b0);
    accept_result("mix");

    // one bubbled capture; the fifth code is only consumed by a retry
    exp_q.push_back(7'b0000011);
    exp_q.push_back(7'b0101111);
    exp_q.push_back(7'b0000011);
    exp_q.push_back(7'b0000011);
    exp_q.push_back(7'b0000011);
    run_conv(40);
`ifdef FLASH_ADC_RETRY_EN
    chk("bub_latches", n_latch, 5);
    chk("bub_latency", done_lat, 20);
    chk("bub_sum", result_sum, 5'd8);
    chk("bub_result", result, 3'd2);
    chk("bub_flag", bubble_err, 1'b0);
`else
    chk("bub_latches", n_latch, 4);
    chk("bub_latency", done_lat, 16);
    chk("bub_sum", result_sum, 5'd11);
    chk("bub_result", result, 3'd3);
    chk("bub_flag", bubble_err, 1'b1);
`endif
    accept_result("bub");
    exp_q.delete();

    // reset during SETTLE of sample 2, partial sum must be discarded
    therm_in = 7'b1111111;
    @(negedge clk);
    start = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
    end
    chk("pre_rst_state", dbg_state, SETTLE);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_latch", cmp_latch, 1'b0);
    chk("mid_rst_valid", result_valid, 1'b0);
    chk("mid_rst_ready", start_ready, 1'b1);
    rst = 1'b0;
    repeat (4) exp_q.push_back(7'b0000000);
    run_conv(40);
    chk("zero_latency", done_lat, 16);
    chk("zero_sum", result_sum, 5'd0);
    chk("zero_result", result, 3'd0);
    accept_result("zero");

    // single-sample, one-cycle settle instance
    therm_in_b = 7'b0011111;
    @(negedge clk);
    start_b = 1'b1;
    done_lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) start_b = 1'b0;
      if (result_valid_b) begin
        done_lat = i - 1;
        break;
      end
    end
    chk("n1_latency", done_lat, 3);
    chk("n1_result", result_b, 3'd5);
    chk("n1_sum", result_sum_b, 3'd5);
    chk("n1_bubble", bubble_err_b, 1'b0);
    result_ready_b = 1'b1;
    @(negedge clk);
    chk("n1_idle_busy", busy_b, 1'b0);
    result_ready_b = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
